// File: rtl/lcd_hd44780_pkg.sv
// lcd_hd44780_pkg: opcodes, DDRAM address map and init FSM
// states shared by the HD44780 controller model.
package lcd_hd44780_pkg;

   // Instruction opcode masks and match values
   localparam logic [7:0] C_CLEAR      = 8'h01;
   localparam logic [7:0] C_HOME_MASK  = 8'hFE;
   localparam logic [7:0] C_HOME_VAL   = 8'h02;
   localparam logic [7:0] C_ENTRY_MASK = 8'hFC;
   localparam logic [7:0] C_ENTRY_VAL  = 8'h04;
   localparam logic [7:0] C_DISP_MASK  = 8'hF8;
   localparam logic [7:0] C_DISP_VAL   = 8'h08;
   localparam logic [7:0] C_SHIFT_MASK = 8'hF0;
   localparam logic [7:0] C_SHIFT_VAL  = 8'h10;
   localparam logic [7:0] C_FSET_MASK  = 8'hE0;
   localparam logic [7:0] C_FSET_VAL   = 8'h20;
   localparam logic [7:0] C_CGRAM_MASK = 8'hC0;
   localparam logic [7:0] C_CGRAM_VAL  = 8'h40;
   localparam logic [7:0] C_DDRAM_MASK = 8'h80;
   localparam logic [7:0] C_DDRAM_VAL  = 8'h80;
   localparam logic [7:0] C_INIT_MASK  = 8'hF0;
   localparam logic [7:0] C_INIT_VAL   = 8'h30;

   // DDRAM line bases and line-end addresses
   localparam logic [6:0] C_LINE0  = 7'h00;
   localparam logic [6:0] C_LINE1  = 7'h40;
   localparam logic [6:0] C_L0_END = 7'h27;
   localparam logic [6:0] C_L1_END = 7'h67;
   localparam logic [6:0] C_N0_END = 7'h4F;

   localparam logic [7:0] C_SPACE = 8'h20;

   typedef enum logic [2:0] {
      S_WAIT0,
      S_WAIT1,
      S_WAIT2,
      S_WAIT3,
      S_READY
   } init_state_t;

   // Address counter step; decrement is the exact
   // inverse of the increment mapping.
   function automatic logic [6:0] ac_step(
      input logic [6:0] ac,
      input logic       id,
      input logic       n
   );
      logic [6:0] r;
      if (id) begin
         if (n && ac == C_L0_END)       r = C_LINE1;
         else if (n && ac == C_L1_END)  r = C_LINE0;
         else if (!n && ac == C_N0_END) r = C_LINE0;
         else                           r = ac + 7'd1;
      end else begin
         if (n && ac == C_LINE1)        r = C_L0_END;
         else if (n && ac == C_LINE0)   r = C_L1_END;
         else if (!n && ac == C_LINE0)  r = C_N0_END;
         else                           r = ac - 7'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 128x8 simple dual-port DDRAM image.
// Ports: i_we/i_waddr/i_wdata sync write; i_raddr -> o_rdata, 1-cycle.
module lcd_ddram (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_we,
   input  logic [6:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic [6:0] i_raddr,
   output logic [7:0] o_rdata
);

   logic [7:0] r_mem [128];
   logic [7:0] r_rdata;

   // Array is deliberately not reset: DDRAM survives reset.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Same-cycle read/write of one address returns old data.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_rdata <= '0;
      else        r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_hd44780_model.sv
// lcd_hd44780_model: HD44780-style receiver for the 8-bit RS/EN/DB bus.
// Ports: i_lcd_* bus in; i_rd_addr/o_rd_data DDRAM read; o_* status/flags.
module lcd_hd44780_model
   import lcd_hd44780_pkg::*;
#(
   parameter int P_BUSY_SHORT = 1850,
   parameter int P_BUSY_LONG  = 76000,
   parameter int P_BUSY_INIT  = 205000,
   parameter int P_EN_MIN     = 12
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_lcd_rs,
   input  logic       i_lcd_en,
   input  logic [7:0] i_lcd_data_bus,
   input  logic [6:0] i_rd_addr,
   output logic [7:0] o_rd_data,
   output logic       o_busy,
   output logic       o_init_done,
   output logic       o_display_on,
   output logic       o_cursor_on,
   output logic       o_blink_on,
   output logic [6:0] o_addr_counter,
   output logic       o_cmd_strobe,
   output logic       o_err_busy,
   output logic       o_err_pulse
);

   localparam int C_BMAX =
      (P_BUSY_INIT > P_BUSY_LONG) ?
      ((P_BUSY_INIT > P_BUSY_SHORT) ? P_BUSY_INIT : P_BUSY_SHORT) :
      ((P_BUSY_LONG > P_BUSY_SHORT) ? P_BUSY_LONG : P_BUSY_SHORT);
   localparam int C_BW = $clog2(C_BMAX + 1);
   localparam int C_EW = $clog2(P_EN_MIN + 1);

   localparam logic [C_BW-1:0] C_B_SHORT = C_BW'(P_BUSY_SHORT);
   localparam logic [C_BW-1:0] C_B_LONG  = C_BW'(P_BUSY_LONG);
   localparam logic [C_BW-1:0] C_B_INIT  = C_BW'(P_BUSY_INIT);
   localparam logic [C_BW-1:0] C_B_ONE   = C_BW'(1);
   localparam logic [C_EW-1:0] C_EN_MIN  = C_EW'(P_EN_MIN);

   logic            r_rs_s1, r_rs_s2;
   logic            r_en_s1, r_en_s2, r_en_prev;
   logic [7:0]      r_db_s1, r_db_s2;
   logic [C_EW-1:0] r_en_cnt;
   logic [C_BW-1:0] r_busy_cnt;
   logic            r_busy;
   logic            r_init_done;
   logic            r_disp, r_cur, r_blink;
   logic            r_strobe;
   logic            r_err_busy, r_err_pulse;
   logic            r_id, r_n;
   logic [6:0]      r_ac;
   logic            r_clr_act;
   logic [6:0]      r_clr_addr;
   init_state_t     r_state;

   logic       w_fall;
   logic       w_short;
   logic       w_is_init;
   logic       w_is_fset;
   logic       w_wr_data;
   logic       w_we;
   logic [6:0] w_waddr;
   logic [7:0] w_wdata;

   assign w_fall    = r_en_prev & ~r_en_s2;
   assign w_short   = (r_en_cnt < C_EN_MIN);
   assign w_is_init = (r_db_s2 & C_INIT_MASK) == C_INIT_VAL;
   assign w_is_fset = (r_db_s2 & C_FSET_MASK) == C_FSET_VAL;

   // DDRAM write happens on the decode edge, alongside the AC step
   assign w_wr_data = w_fall & ~w_short & ~r_busy
                    & r_rs_s2 & (r_state == S_READY);

   // Clear sweep and data writes never overlap: the sweep runs
   // inside the busy window, which blocks data writes.
   assign w_we    = w_wr_data | r_clr_act;
   assign w_waddr = r_clr_act ? r_clr_addr : r_ac;
   assign w_wdata = r_clr_act ? C_SPACE : r_db_s2;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rs_s1     <= 1'b0;
         r_rs_s2     <= 1'b0;
         r_en_s1     <= 1'b0;
         r_en_s2     <= 1'b0;
         r_en_prev   <= 1'b0;
         r_db_s1     <= '0;
         r_db_s2     <= '0;
         r_en_cnt    <= '0;
         r_busy_cnt  <= '0;
         r_busy      <= 1'b0;
         r_init_done <= 1'b0;
         r_disp      <= 1'b0;
         r_cur       <= 1'b0;
         r_blink     <= 1'b0;
         r_strobe    <= 1'b0;
         r_err_busy  <= 1'b0;
         r_err_pulse <= 1'b0;
         r_id        <= 1'b1;
         r_n         <= 1'b0;
         r_ac        <= '0;
         r_clr_act   <= 1'b0;
         r_clr_addr  <= '0;
         r_state     <= S_WAIT0;
      end else begin
         r_rs_s1   <= i_lcd_rs;
         r_rs_s2   <= r_rs_s1;
         r_en_s1   <= i_lcd_en;
         r_en_s2   <= r_en_s1;
         r_en_prev <= r_en_s2;
         r_db_s1   <= i_lcd_data_bus;
         r_db_s2   <= r_db_s1;
         r_strobe  <= 1'b0;

         // EN high width, saturating at the minimum legal width
         if (r_en_s2) begin
            if (r_en_cnt != C_EN_MIN) r_en_cnt <= r_en_cnt + 1'b1;
         end else begin
            r_en_cnt <= '0;
         end

         if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - C_B_ONE;
            r_busy     <= (r_busy_cnt != C_B_ONE);
         end

         if (r_clr_act) begin
            r_clr_addr <= r_clr_addr + 7'd1;
            if (r_clr_addr == 7'h7F) r_clr_act <= 1'b0;
         end

         if (w_fall) begin
            if (w_short) begin
               r_err_pulse <= 1'b1;
            end else if (r_busy) begin
               r_err_busy <= 1'b1;
            end else begin
               unique case (r_state)
                  S_WAIT0: begin
                     if (!r_rs_s2 && w_is_init) begin
                        r_state    <= S_WAIT1;
                        r_strobe   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_busy_cnt <= C_B_INIT;
                     end else begin
                        r_state <= S_WAIT0;
                     end
                  end
                  S_WAIT1: begin
                     if (!r_rs_s2 && w_is_init) begin
                        r_state    <= S_WAIT2;
                        r_strobe   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_busy_cnt <= C_B_SHORT;
                     end else begin
                        r_state <= S_WAIT0;
                     end
                  end
                  S_WAIT2: begin
                     if (!r_rs_s2 && w_is_init) begin
                        r_state    <= S_WAIT3;
                        r_strobe   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_busy_cnt <= C_B_SHORT;
                     end else begin
                        r_state <= S_WAIT0;
                     end
                  end
                  S_WAIT3: begin
                     if (!r_rs_s2 && w_is_fset) begin
                        r_state     <= S_READY;
                        r_n         <= r_db_s2[3];
                        r_init_done <= 1'b1;
                        r_strobe    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_busy_cnt  <= C_B_SHORT;
                     end else begin
                        r_state <= S_WAIT0;
                     end
                  end
                  S_READY: begin
                     r_strobe   <= 1'b1;
                     r_busy     <= 1'b1;
                     r_busy_cnt <= C_B_SHORT;
                     if (r_rs_s2) begin
                        r_ac <= ac_step(r_ac, r_id, r_n);
                     end else begin
                        unique case (1'b1)
                           (r_db_s2 == C_CLEAR): begin
                              r_clr_act  <= 1'b1;
                              r_clr_addr <= '0;
                              r_ac       <= '0;
                              r_id       <= 1'b1;
                              r_busy_cnt <= C_B_LONG;
                           end
                           ((r_db_s2 & C_HOME_MASK) == C_HOME_VAL): begin
                              r_ac       <= '0;
                              r_busy_cnt <= C_B_LONG;
                           end
                           ((r_db_s2 & C_ENTRY_MASK) == C_ENTRY_VAL): begin
                              r_id <= r_db_s2[1];
                           end
                           ((r_db_s2 & C_DISP_MASK) == C_DISP_VAL): begin
                              r_disp  <= r_db_s2[2];
                              r_cur   <= r_db_s2[1];
                              r_blink <= r_db_s2[0];
                           end
                           ((r_db_s2 & C_SHIFT_MASK) == C_SHIFT_VAL),
                           ((r_db_s2 & C_CGRAM_MASK) == C_CGRAM_VAL): begin
                           end
                           w_is_fset: begin
                              r_n <= r_db_s2[3];
                           end
                           ((r_db_s2 & C_DDRAM_MASK) == C_DDRAM_VAL): begin
                              r_ac <= r_db_s2[6:0];
                           end
                           default: begin
                           end
                        endcase
                     end
                  end
                  default: r_state <= S_WAIT0;
               endcase
            end
         end
      end
   end

   lcd_ddram u_ddram (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (i_rd_addr),
      .o_rdata (o_rd_data)
   );

   assign o_busy         = r_busy;
   assign o_init_done    = r_init_done;
   assign o_display_on   = r_disp;
   assign o_cursor_on    = r_cur;
   assign o_blink_on     = r_blink;
   assign o_addr_counter = r_ac;
   assign o_cmd_strobe   = r_strobe;
   assign o_err_busy     = r_err_busy;
   assign o_err_pulse    = r_err_pulse;

endmodule

// File: tb/tb_lcd_hd44780_model.sv
// tb_lcd_hd44780_model: bus-level stimulus against a screen-image
// reference model (linear line positions, plain arrays).
module tb_lcd_hd44780_model;

   localparam int P_SHORT = 50;
   localparam int P_LONG  = 400;
   localparam int P_INIT  = 1000;
   localparam int P_EN    = 12;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_lcd_rs = 1'b0;
   logic       i_lcd_en = 1'b0;
   logic [7:0] i_lcd_data_bus = 8'h00;
   logic [6:0] i_rd_addr = 7'h00;
   logic [7:0] o_rd_data;
   logic       o_busy;
   logic       o_init_done;
   logic       o_display_on;
   logic       o_cursor_on;
   logic       o_blink_on;
   logic [6:0] o_addr_counter;
   logic       o_cmd_strobe;
   logic       o_err_busy;
   logic       o_err_pulse;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] m_mem [128];
   logic [6:0] m_ac = 7'h00;
   bit m_id = 1'b1;
   bit m_n  = 1'b0;
   bit m_d, m_c, m_b;

   lcd_hd44780_model #(
      .P_BUSY_SHORT (P_SHORT),
      .P_BUSY_LONG  (P_LONG),
      .P_BUSY_INIT  (P_INIT),
      .P_EN_MIN     (P_EN)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_lcd_rs       (i_lcd_rs),
      .i_lcd_en       (i_lcd_en),
      .i_lcd_data_bus (i_lcd_data_bus),
      .i_rd_addr      (i_rd_addr),
      .o_rd_data      (o_rd_data),
      .o_busy         (o_busy),
      .o_init_done    (o_init_done),
      .o_display_on   (o_display_on),
      .o_cursor_on    (o_cursor_on),
      .o_blink_on     (o_blink_on),
      .o_addr_counter (o_addr_counter),
      .o_cmd_strobe   (o_cmd_strobe),
      .o_err_busy     (o_err_busy),
      .o_err_pulse    (o_err_pulse)
   );

   always #10 i_clk = ~i_clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Screen as two 40-char lines (N=1) or one 80-char line (N=0)
   function automatic logic [6:0] m_step(input logic [6:0] a,
                                         input bit inc,
                                         input bit n);
      int ai, idx;
      ai = int'(a);
      if (n) idx = (ai >= 64) ? ai - 24 : ai;
      else   idx = ai;
      idx = inc ? (idx + 1) % 80 : (idx + 79) % 80;
      if (n && idx >= 40) idx = idx + 24;
      return 7'(idx);
   endfunction

   task automatic mw(input bit rs, input logic [7:0] db);
      if (rs) begin
         m_mem[m_ac] = db;
         m_ac = m_step(m_ac, m_id, m_n);
      end else if (db == 8'h01) begin
         for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
         m_ac = 7'h00;
         m_id = 1'b1;
      end else if (db >= 8'h02 && db < 8'h04) begin
         m_ac = 7'h00;
      end else if (db >= 8'h04 && db < 8'h08) begin
         m_id = db[1];
      end else if (db >= 8'h08 && db < 8'h10) begin
         {m_d, m_c, m_b} = db[2:0];
      end else if (db >= 8'h20 && db < 8'h40) begin
         m_n = db[3];
      end else if (db >= 8'h80) begin
         m_ac = db[6:0];
      end
   endtask

   // Pin pulse; returns the strobe seen 3 edges after EN drops
   task automatic pulse(input bit rs, input logic [7:0] db,
                        input int w, input int pre,
                        output bit stb);
      repeat (pre) @(negedge i_clk);
      i_lcd_rs = rs;
      i_lcd_data_bus = db;
      i_lcd_en = 1'b1;
      repeat (w) @(negedge i_clk);
      i_lcd_en = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 stb = o_cmd_strobe;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 5000 && o_busy; i++) @(negedge i_clk);
      chk("busy_stuck", 32'(o_busy), 0);
   endtask

   task automatic cmd(input bit rs, input logic [7:0] db,
                      input bit acc);
      bit stb;
      pulse(rs, db, P_EN, 1, stb);
      chk(rs ? "data_strobe" : "cmd_strobe", 32'(stb), 32'(acc));
      wait_idle();
   endtask

   task automatic wr(input bit rs, input logic [7:0] db);
      mw(rs, db);
      cmd(rs, db, 1'b1);
   endtask

   task automatic rd(input logic [6:0] a, output logic [7:0] d);
      @(negedge i_clk);
      i_rd_addr = a;
      @(posedge i_clk);
      #1 d = o_rd_data;
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] light [5];
      bit stb;
      int cnt;
      int op, li;

      light = '{8'h4C, 8'h49, 8'h47, 8'h48, 8'h54};

      repeat (3) @(negedge i_clk);
      chk("reset_outs",
          {o_busy, o_init_done, o_display_on, o_cursor_on,
           o_blink_on, o_cmd_strobe, o_err_busy, o_err_pulse,
           1'b0, o_addr_counter, o_rd_data}, 0);
      @(negedge i_clk);
      i_rst = 1'b1;

      cmd(1'b1, 8'h41, 1'b0);
      cmd(1'b0, 8'h30, 1'b1);
      cmd(1'b0, 8'h08, 1'b0);
      chk("abort_no_init", 32'(o_init_done), 0);

      cmd(1'b0, 8'h30, 1'b1);
      cmd(1'b0, 8'h30, 1'b1);
      cmd(1'b0, 8'h30, 1'b1);
      cmd(1'b0, 8'h38, 1'b1);
      m_n = 1'b1;
      @(posedge i_clk);
      #1 chk("strobe_1cyc", 32'(o_cmd_strobe), 0);
      wr(1'b0, 8'h08);
      wr(1'b0, 8'h01);
      wr(1'b0, 8'h06);
      wr(1'b0, 8'h0F);
      chk("init_flags",
          {o_init_done, o_display_on, o_cursor_on, o_blink_on},
          {1'b1, m_d, m_c, m_b});
      chk("init_dcb", {o_display_on, o_cursor_on, o_blink_on}, 3'b111);
      chk("init_ac", 32'(o_addr_counter), 0);
      chk("init_errs", {o_err_busy, o_err_pulse}, 0);

      for (int i = 0; i < 5; i++) wr(1'b1, light[i]);
      wr(1'b0, 8'hC0);
      wr(1'b1, 8'h31);
      chk("light_ac", 32'(o_addr_counter), 32'h41);
      for (int i = 0; i < 5; i++) begin
         rd(7'(i), d);
         chk("light_ram", 32'(d), 32'(light[i]));
      end
      rd(7'h40, d);
      chk("line2_ram", 32'(d), 32'h31);

      wr(1'b0, 8'hA7);
      wr(1'b1, 8'h61);
      chk("wrap_27_40", 32'(o_addr_counter), 32'h40);
      wr(1'b0, 8'hE7);
      wr(1'b1, 8'h62);
      chk("wrap_67_00", 32'(o_addr_counter), 32'h00);
      wr(1'b0, 8'hC0);
      wr(1'b0, 8'h04);
      wr(1'b1, 8'h63);
      chk("wrap_dec_40_27", 32'(o_addr_counter), 32'h27);
      wr(1'b0, 8'h06);
      chk("wrap_model_ac", 32'(o_addr_counter), 32'(m_ac));

      // write during clear busy window
      pulse(1'b0, 8'h01, P_EN, 1, stb);
      chk("clr_strobe", 32'(stb), 1);
      mw(1'b0, 8'h01);
      pulse(1'b1, 8'h55, P_EN, 200, stb);
      chk("busy_wr_strobe", 32'(stb), 0);
      chk("busy_wr_err", 32'(o_err_busy), 1);
      wait_idle();
      chk("busy_wr_ac", 32'(o_addr_counter), 0);
      rd(7'h00, d);
      chk("busy_wr_ram", 32'(d), 32'h20);
      wr(1'b1, 8'h56);
      chk("after_busy_ac", 32'(o_addr_counter), 1);

      // write detected exactly when busy falls, then one cycle early
      pulse(1'b1, 8'h41, P_EN, 1, stb);
      chk("bnd_first", 32'(stb), 1);
      mw(1'b1, 8'h41);
      pulse(1'b1, 8'h42, P_EN, P_SHORT - 13, stb);
      chk("bnd_exact_acc", 32'(stb), 1);
      mw(1'b1, 8'h42);
      pulse(1'b1, 8'h43, P_EN, P_SHORT - 14, stb);
      chk("bnd_early_rej", 32'(stb), 0);
      wait_idle();
      chk("bnd_ac", 32'(o_addr_counter), 32'(m_ac));

      // fill line 2, then clear and time the busy window
      wr(1'b0, 8'hC0);
      for (int i = 0; i < 40; i++) wr(1'b1, 8'($urandom_range(33, 126)));
      rd(7'h53, d);
      chk("line2_fill", 32'(d), 32'(m_mem[7'h53]));
      pulse(1'b0, 8'h01, P_EN, 1, stb);
      chk("clr2_strobe", 32'(stb), 1);
      mw(1'b0, 8'h01);
      cnt = 0;
      for (int i = 0; i < P_LONG + 200; i++) begin
         @(negedge i_clk);
         if (!o_busy) break;
         cnt++;
      end
      chk("clr_busy_len", 32'(cnt), 32'(P_LONG));
      for (int i = 0; i < 128; i++) begin
         rd(7'(i), d);
         chk("clr_ram", 32'(d), 32'h20);
      end

      for (int k = 0; k < 60; k++) begin
         op = $urandom_range(0, 5);
         if (op <= 3) begin
            wr(1'b1, 8'($urandom_range(0, 255)));
         end else if (op == 4) begin
            li = $urandom_range(0, 79);
            wr(1'b0, 8'h80 | 8'((li < 40) ? li : li + 24));
         end else begin
            wr(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
         end
         chk("rand_ac", 32'(o_addr_counter), 32'(m_ac));
      end
      for (int i = 0; i < 128; i++) begin
         rd(7'(i), d);
         chk("rand_ram", 32'(d), 32'(m_mem[i]));
      end

      // one-line mode wraps at 0x4F
      wr(1'b0, 8'h30);
      wr(1'b0, 8'h06);
      wr(1'b0, 8'hCF);
      wr(1'b1, 8'h5A);
      chk("n0_wrap_inc", 32'(o_addr_counter), 32'h00);
      wr(1'b0, 8'h04);
      wr(1'b1, 8'h5B);
      chk("n0_wrap_dec", 32'(o_addr_counter), 32'h4F);
      chk("n0_model_ac", 32'(o_addr_counter), 32'(m_ac));

      pulse(1'b1, 8'h41, 5, 1, stb);
      chk("short_strobe", 32'(stb), 0);
      chk("short_err", 32'(o_err_pulse), 1);
      wait_idle();
      chk("short_ac", 32'(o_addr_counter), 32'(m_ac));
      rd(m_ac, d);
      chk("short_ram", 32'(d), 32'(m_mem[m_ac]));

      pulse(1'b1, 8'h51, P_EN, 1, stb);
      chk("rst_pre_strobe", 32'(stb), 1);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_init_done), 0);
      @(negedge i_clk);
      i_rst = 1'b1;
      cmd(1'b1, 8'h52, 1'b0);
      chk("rst_ac", 32'(o_addr_counter), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_hd44780_model.md
# lcd_hd44780_model

Synthesizable HD44780-compatible LCD controller model: the receiving end of the 8-bit parallel RS/EN/DB bus that the 16x2 LCD driver produces. It decodes instructions and data on EN falling edges and enforces controller busy times. It maintains a 2-line DDRAM image and exposes that image through a read port. It sits in the bench and FPGA loopback builds in place of the physical display, so a scoreboard or debug UART can check the exact characters on screen.

## Interface
- P_BUSY_SHORT, 1850: busy cycles after a normal instruction or data write (37 µs at 50 MHz).
- P_BUSY_LONG, 76000: busy cycles after clear display or return home (1.52 ms).
- P_BUSY_INIT, 205000: busy cycles after the first 0x3X function set (4.1 ms).
- P_EN_MIN, 12: minimum EN high width in cycles (240 ns).
- i_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  reset, asynchronous, active-low.
- i_lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- i_lcd_en  in  1  enable strobe; the model latches on its falling edge.
- i_lcd_data_bus  in  8  DB7..DB0.
- i_rd_addr  in  7  DDRAM read address.
- o_rd_data  out  8  DDRAM[i_rd_addr], registered.
- o_busy  out  1  busy flag.
- o_init_done  out  1  init sequence recognised.
- o_display_on, o_cursor_on, o_blink_on  out  1 each  D/C/B bits.
- o_addr_counter  out  7  current address counter (AC).
- o_cmd_strobe  out  1  one-cycle pulse per accepted write.
- o_err_busy  out  1  sticky: a write arrived while busy.
- o_err_pulse  out  1  sticky: an EN pulse was shorter than P_EN_MIN.

## Operation
- RS, EN and DB pass through a 2-flop synchronizer. A falling edge on the synchronized EN is the write event. RS and DB are taken from the synchronized values in that same cycle.
- An EN high counter saturates at P_EN_MIN. On a falling edge with count < P_EN_MIN: event ignored, o_err_pulse set.
- On a falling edge while o_busy=1: event ignored, o_err_busy set, busy counter untouched.
- Init FSM states:
  - S_WAIT0: idle. An instruction matching 0011_xxxx moves to S_WAIT1 and loads P_BUSY_INIT.
  - S_WAIT1: a second 0011_xxxx moves to S_WAIT2.
  - S_WAIT2: a third 0011_xxxx moves to S_WAIT3.
  - S_WAIT3: the next 001x_xxxx (function set) latches N, sets o_init_done and moves to S_READY.
  - In S_WAIT0..S_WAIT3, any other instruction or any data write is ignored with no busy time, and the FSM returns to S_WAIT0.
- S_READY decode (RS=0):
  - 0x01 clear: DDRAM filled with 0x20 by a sweep of one address per cycle over 0..127; AC←0; I/D←1; busy P_BUSY_LONG.
  - 0x02/0x03 home: AC←0; busy P_BUSY_LONG.
  - 0x04–0x07 entry mode: latch I/D and S. S has no effect.
  - 0x08–0x0F: latch D/C/B.
  - 0x10–0x1F shift and 0x40–0x7F CGRAM address: accepted, no state change.
  - 0x20–0x3F function set: latch N.
  - 0x80–0xFF: AC←DB[6:0].
  - All non-clear/home instructions: busy P_BUSY_SHORT.
- Data write (RS=1) in S_READY: DDRAM[AC]←DB, then AC steps; busy P_BUSY_SHORT.
- AC step with I/D=1:
  - N=1: 0x27→0x40, 0x67→0x00, otherwise +1 mod 128.
  - N=0: 0x4F→0x00, otherwise +1.
- AC step with I/D=0: exact reverse of the increment mapping.
- Reset: all outputs 0, FSM→S_WAIT0, busy counter 0, I/D=1, N=0. DDRAM contents are not reset.

## Timing
- Pin EN falling edge to o_cmd_strobe and o_busy high: 3 cycles (2 synchronizer stages plus 1 decode cycle). AC, flags and the DDRAM write update in the same cycle as o_cmd_strobe.
- o_busy stays high exactly P_BUSY_* cycles, then falls. A write whose detected falling edge lands in the cycle o_busy falls is accepted.
- The clear sweep finishes in 128 cycles, inside the busy window. During the sweep, o_rd_data may return stale bytes.
- o_rd_data latency is 1 cycle from i_rd_addr. A read and a write to the same address in the same cycle return the old data.
- Reset asserted mid-busy or mid-sweep aborts immediately. After release the model waits for a full init sequence.

## Structure
- Package lcd_hd44780_pkg holds:
  - instruction opcode masks and values;
  - line base addresses 0x00/0x40 and line-end addresses 0x27/0x67/0x4F;
  - the space character 0x20;
  - the init FSM state enum.
- Sub-module lcd_ddram: 128x8 simple dual-port RAM with one synchronous write port (shared by data writes and the clear sweep) and one registered read port.

## Test plan
- Driver-timed init: 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0F → o_init_done=1, o_display_on=1, o_cursor_on=1, o_blink_on=1, AC=0, no error flags.
- After init, write "LIGHT" (0x4C 0x49 0x47 0x48 0x54), then 0xC0, then '1' (0x31) → DDRAM[0..4]="LIGHT", DDRAM[0x40]=0x31, AC=0x41.
- AC=0x27, one data write → AC=0x40. AC=0x67, one data write → AC=0x00. With 0x04 (I/D=0) at AC=0x40, one data write → AC=0x27.
- Data write issued 1000 cycles after a 0x01 → ignored, o_err_busy=1, DDRAM unchanged. A write issued after busy falls → accepted.
- Line 2 filled, then 0x01 → all 128 locations read 0x20, o_busy high for 76000 cycles.
- EN pulse 5 cycles wide carrying 0x41 → o_err_pulse=1, no write, AC unchanged. Reset asserted mid-busy → o_busy=0, o_init_done=0 on the next cycle.
